uart_tx_ctrl: RTL
=================

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter line: FIFO_DEPTH, 16, software TX FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter line: DIV_RESET, 16'd867, baud divisor after reset (115200 baud at 100 MHz).
REQ-003 SHALL have port: clk  input  1  clock, all logic on rising edge.
REQ-004 SHALL have port: rstn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port: mmio_addr  input  4  byte offset of register.
REQ-006 SHALL have port: mmio_wr  input  1  write strobe, one cycle per write.
REQ-007 SHALL have port: mmio_rd  input  1  read strobe, one cycle per read.
REQ-008 SHALL have port: mmio_wdata  input  32  write data.
REQ-009 SHALL have port: mmio_rdata  output  32  read data, registered.
REQ-010 SHALL have port: baud_tick  output  1  one-cycle pulse every (divisor+1) clocks, drives uart_tx_phy.
REQ-011 SHALL have port: tx_data  output  8  byte at FIFO head.
REQ-012 SHALL have port: tx_valid  output  1  FIFO non-empty.
REQ-013 SHALL have port: tx_ready  input  1  uart_tx_phy can accept.
REQ-014 SHALL have port: irq  output  1  TX low-water interrupt (0 when feature compiled out).

Function
REQ-015 SHALL map 0x0 TXDATA: write pushes wdata[7:0]; reads return 0.
REQ-016 SHALL map 0x4 STATUS: bit0 empty, bit1 full, bit2 overflow (sticky), bits[15:8] FIFO level; writing 1 to bit2 clears overflow.
REQ-017 SHALL map 0x8 BAUDDIV: 16-bit R/W divisor in bits[15:0]; a write also zeroes the tick counter.
REQ-018 SHALL return 0 for unmapped offsets and ignore writes to them.
REQ-019 SHALL present mmio_rdata one cycle after mmio_rd; it holds its value until the next read.
REQ-020 SHALL drop a TXDATA write when FIFO full (pre-cycle state) and set overflow, even if a pop occurs in the same cycle.
REQ-021 SHALL drive tx_valid=!empty, tx_data=head combinationally; pop when tx_valid && tx_ready.
REQ-022 SHALL keep level unchanged on simultaneous accepted push and pop; pointers wrap modulo FIFO_DEPTH with an extra wrap bit.
REQ-023 SHALL generate baud_tick when counter==divisor, then reset counter to 0; divisor 0 gives a tick every cycle.
REQ-024 SHALL give the overflow-set priority over the software clear when both occur in the same cycle.

Reset
REQ-025 SHALL on !rstn set pointers 0, overflow 0, divisor DIV_RESET, counter 0, mmio_rdata 0, baud_tick 0, irq 0; tx_valid therefore 0.
REQ-026 SHALL discard FIFO contents on reset mid-transfer; FIFO storage itself is not reset.

Configuration
REQ-027 SHALL compile the interrupt logic only when UART_TX_IRQ_EN is defined.
REQ-028 With UART_TX_IRQ_EN: 0xC IRQCTRL R/W, bit0 enable, bits[15:8] threshold; irq registered, high while enable && level<=threshold.
REQ-029 Without UART_TX_IRQ_EN: irq tied 0, offset 0xC reads 0 and ignores writes.

Structure
REQ-030 SHALL place register offsets, STATUS bit positions and TX FIFO size/bit constants in package uart_defines.
REQ-031 SHALL implement the tick generator as sub-module uart_baud_gen (clk, rstn, divisor, clear, baud_tick).

Verification
REQ-032 Reset then read 0x4 -> rdata 0x0000_0001; read 0x8 -> 0x0000_0363.
REQ-033 tx_ready=0, write 0x41,0x42,0x43 to 0x0 -> STATUS level 3; raise tx_ready -> tx_data 0x41,0x42,0x43 on consecutive pops, then empty.
REQ-034 tx_ready=0, write 17 bytes -> full=1, overflow=1, level 16; write 0x4 bit2=1 -> overflow 0.
REQ-035 Write 0x8=3 -> baud_tick period exactly 4 cycles; write 0 -> tick every cycle.
REQ-036 Full FIFO, push and pop same cycle -> push dropped, overflow set, level 15.
REQ-037 With UART_TX_IRQ_EN, IRQCTRL enable, threshold 2, 4 bytes queued -> irq rises the cycle after level reaches 2.

Source files
------------

// File: rtl/uart_defines.sv
// uart_defines: register map, STATUS/IRQCTRL bit positions and TX FIFO
// constants shared by the UART TX controller files.
package uart_defines;

  localparam logic [3:0] ADDR_TXDATA  = 4'h0;
  localparam logic [3:0] ADDR_STATUS  = 4'h4;
  localparam logic [3:0] ADDR_BAUDDIV = 4'h8;
  localparam logic [3:0] ADDR_IRQCTRL = 4'hC;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_LVL_LSB = 8;
  localparam int ST_LVL_W   = 8;

  localparam int IRQ_EN_BIT  = 0;
  localparam int IRQ_THR_LSB = 8;
  localparam int IRQ_THR_W   = 8;

  localparam int TXF_DEPTH = 16;
  localparam int TXF_DW    = 8;
  localparam int DIV_W     = 16;

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running divisor counter, one-cycle tick every
// (divisor+1) clocks; clear restarts the count from zero.
module uart_baud_gen
  import uart_defines::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic [DIV_W-1:0] divisor,
  input  logic             clear,
  output logic             baud_tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             hit;

  assign hit = (cnt_q == divisor);

  always_comb begin
    cnt_d  = cnt_q + DIV_W'(1);
    tick_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (hit) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign baud_tick = tick_q;

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: MMIO front end for the UART transmitter (TX FIFO, baud
// divisor). Low-water interrupt is compiled in only with UART_TX_IRQ_EN.
module uart_tx_ctrl
  import uart_defines::*;
#(
  parameter int               FIFO_DEPTH = TXF_DEPTH,
  parameter logic [DIV_W-1:0] DIV_RESET  = 16'd867
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [3:0]        mmio_addr,
  input  logic              mmio_wr,
  input  logic              mmio_rd,
  input  logic [31:0]       mmio_wdata,
  output logic [31:0]       mmio_rdata,
  output logic              baud_tick,
  output logic [TXF_DW-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              irq
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [TXF_DW-1:0]   mem_q [FIFO_DEPTH];
  logic [AW:0]         wptr_q, wptr_d;
  logic [AW:0]         rptr_q, rptr_d;
  logic [AW:0]         level;
  logic [ST_LVL_W-1:0] lvl8;
  logic                ovf_q, ovf_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [31:0]         status;
  logic [31:0]         irqctrl;
  logic                empty, full;
  logic                wr_tx, wr_st, wr_div;
  logic                push, pop;
  logic                unused_w;

  assign unused_w = ^mmio_wdata[31:16];

  assign level = wptr_q - rptr_q;
  assign lvl8  = ST_LVL_W'(level);
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  assign wr_tx  = mmio_wr && (mmio_addr == ADDR_TXDATA);
  assign wr_st  = mmio_wr && (mmio_addr == ADDR_STATUS);
  assign wr_div = mmio_wr && (mmio_addr == ADDR_BAUDDIV);

  // Full is judged on the pre-cycle state, so a same-cycle pop never rescues a push.
  assign push = wr_tx && !full;
  assign pop  = tx_valid && tx_ready;

  assign tx_valid = !empty;
  assign tx_data  = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    status                            = '0;
    status[ST_EMPTY]                  = empty;
    status[ST_FULL]                   = full;
    status[ST_OVF]                    = ovf_q;
    status[ST_LVL_LSB +: ST_LVL_W]    = lvl8;
  end

  always_comb begin
    wptr_d  = push ? wptr_q + PTR_ONE : wptr_q;
    rptr_d  = pop  ? rptr_q + PTR_ONE : rptr_q;
    div_d   = wr_div ? mmio_wdata[DIV_W-1:0] : div_q;
    ovf_d   = ovf_q;
    if (wr_st && mmio_wdata[ST_OVF]) ovf_d = 1'b0;
    if (wr_tx && full)               ovf_d = 1'b1;
    rdata_d = rdata_q;
    if (mmio_rd) begin
      case (mmio_addr)
        ADDR_STATUS:  rdata_d = status;
        ADDR_BAUDDIV: rdata_d = {16'b0, div_q};
        ADDR_IRQCTRL: rdata_d = irqctrl;
        default:      rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= mmio_wdata[TXF_DW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      ovf_q   <= 1'b0;
      div_q   <= DIV_RESET;
      rdata_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      ovf_q   <= ovf_d;
      div_q   <= div_d;
      rdata_q <= rdata_d;
    end
  end

  assign mmio_rdata = rdata_q;

`ifdef UART_TX_IRQ_EN
  logic                 irq_en_q;
  logic [IRQ_THR_W-1:0] thr_q;
  logic                 irq_q;
  logic                 wr_irq;

  assign wr_irq = mmio_wr && (mmio_addr == ADDR_IRQCTRL);

  always_comb begin
    irqctrl                            = '0;
    irqctrl[IRQ_EN_BIT]                = irq_en_q;
    irqctrl[IRQ_THR_LSB +: IRQ_THR_W]  = thr_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      irq_en_q <= 1'b0;
      thr_q    <= '0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_irq) begin
        irq_en_q <= mmio_wdata[IRQ_EN_BIT];
        thr_q    <= mmio_wdata[IRQ_THR_LSB +: IRQ_THR_W];
      end
      irq_q <= irq_en_q && (lvl8 <= thr_q);
    end
  end

  assign irq = irq_q;
`else
  assign irqctrl = '0;
  assign irq     = 1'b0;
`endif

  uart_baud_gen u_baud (
    .clk       (clk),
    .rstn      (rstn),
    .divisor   (div_q),
    .clear     (wr_div),
    .baud_tick (baud_tick)
  );

endmodule
